// File: rtl/sd_pkg.sv
// Shared SD-bus definitions: CRC7 polynomial, frame sizes and the
// command transmitter state type.
package sd_pkg;

    localparam logic [6:0]  CRC7_POLY           = 7'h09;
    localparam int unsigned SD_CMD_FRAME_BITS   = 48;
    localparam int unsigned SD_CMD_PAYLOAD_BITS = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SHIFT,
        ST_CRC,
        ST_END,
        ST_GAP
    } sd_cmd_state_t;

endpackage

// File: rtl/sd_cmd_tx_if.sv
// Command request channel between the host command controller and the
// SD command transmitter.
interface sd_cmd_tx_if;

    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_index;
    logic [31:0] req_arg;
    logic        busy;
    logic        done;

    modport master (
        output req_valid, req_index, req_arg,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_index, req_arg,
        output req_ready, busy, done
    );

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled clock, MSB first.
// Shared by the command transmitter and the response receiver.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic fb;

    assign fb = bit_in ^ crc[6];

    // CRC register: clear has priority over a data bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD command line transmitter: serialises {start, transmit, index, arg,
// CRC7, end} onto CMD and generates a continuous SD clock.
// Optional macro SD_CMD_GAP_EN appends GAP_BITS idle-high driven bits
// after the end bit before the block reports done.
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned GAP_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    sd_cmd_tx_if.slave  req,
    output logic        sd_clk,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe
);

`ifdef SD_CMD_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam int unsigned DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [5:0] PAY_LAST  = 6'(SD_CMD_PAYLOAD_BITS - 1);
    localparam logic [5:0] GAP_LAST  = 6'(GAP_BITS - 1);

    sd_cmd_state_t state, state_n;

    logic [DW-1:0]                    div_cnt;
    logic                             tick;
    logic [5:0]                       bit_cnt, bit_cnt_n;
    logic [SD_CMD_PAYLOAD_BITS-1:0]   shreg, shreg_n;
    logic                             out_n, oe_n;
    logic                             accept;
    logic                             crc_clr, crc_en;
    logic [6:0]                       crc;
    logic                             done_c;

    assign tick          = (div_cnt == DIV_LAST);
    assign sd_clk        = (div_cnt >= DIV_HALF);
    assign req.req_ready = (state == ST_IDLE);
    assign req.busy      = (state != ST_IDLE);
    assign req.done      = done_c;
    assign accept        = req.req_valid && req.req_ready;

    // Free-running SD bit divider; tick marks the sd_clk falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    // FSM state, payload shifter and CMD line registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            sd_cmd_out <= 1'b1;
            sd_cmd_oe  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            sd_cmd_out <= out_n;
            sd_cmd_oe  <= oe_n;
        end
    end

    // Next state and line values; the line only moves on ticks.
    // bit_cnt holds the bits still to be driven after the current one.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        out_n     = sd_cmd_out;
        oe_n      = sd_cmd_oe;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        done_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_WAIT;
                    shreg_n = {2'b01, req.req_index, req.req_arg};
                    crc_clr = 1'b1;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    out_n     = shreg[SD_CMD_PAYLOAD_BITS-1];
                    oe_n      = 1'b1;
                    shreg_n   = {shreg[SD_CMD_PAYLOAD_BITS-2:0], 1'b0};
                    crc_en    = 1'b1;
                    bit_cnt_n = PAY_LAST;
                    state_n   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (bit_cnt != '0) begin
                        out_n     = shreg[SD_CMD_PAYLOAD_BITS-1];
                        shreg_n   = {shreg[SD_CMD_PAYLOAD_BITS-2:0], 1'b0};
                        crc_en    = 1'b1;
                        bit_cnt_n = bit_cnt - 1'b1;
                    end else begin
                        // CRC register already holds all 40 payload bits here
                        out_n     = crc[6];
                        bit_cnt_n = 6'd6;
                        state_n   = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (tick) begin
                    if (bit_cnt != '0) begin
                        out_n     = crc[bit_cnt[2:0] - 3'd1];
                        bit_cnt_n = bit_cnt - 1'b1;
                    end else begin
                        out_n   = 1'b1;
                        state_n = ST_END;
                    end
                end
            end
            ST_END: begin
                if (tick) begin
                    out_n = 1'b1;
                    if (GAP_EN) begin
                        bit_cnt_n = GAP_LAST;
                        state_n   = ST_GAP;
                    end else begin
                        oe_n    = 1'b0;
                        done_c  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    out_n = 1'b1;
                    if (bit_cnt != '0) begin
                        bit_cnt_n = bit_cnt - 1'b1;
                    end else begin
                        oe_n    = 1'b0;
                        done_c  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                oe_n    = 1'b0;
                out_n   = 1'b1;
            end
        endcase
    end

    sd_crc7 u_crc7 (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (shreg[SD_CMD_PAYLOAD_BITS-1]),
        .crc    (crc)
    );

endmodule
